multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle sequencer for the RV32I core. It replaces the single-cycle decoder with a Moore FSM
//  that steps the shared datapath (one ALU, one unified memory port) through fetch, decode,
//  execute, memory and writeback. It waits on a memory-ready handshake and traps illegal opcodes.
// PARAMETERS
//  (none)
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  asynchronous, active-low (0 = reset)
//  opcode        in   7  instr[6:0] from instruction register
//  funct3        in   3  instr[14:12]
//  funct7b5      in   1  instr[30]
//  N,Z,C,V       in   1  ALU flags of current ALU op (C=1: no borrow on a-b)
//  mem_ready     in   1  memory access completes this cycle
//  pc_wren       out  1  PC register load
//  ir_wren       out  1  instruction + oldPC register load
//  adr_sel       out  1  memory address: 0=PC, 1=alu_out register
//  dmem_wren     out  1  memory write strobe
//  regfile_wren  out  1  register file write
//  alu_asel      out  2  00=PC, 01=oldPC, 10=rs1
//  alu_bsel      out  2  00=rs2, 01=imm, 10=const 4
//  result_sel    out  2  00=alu_out reg, 01=mem data reg, 10=ALU_result direct
//  ximm_sel      out  2  00=I, 01=S, 10=B, 11=J
//  ALU_control   out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
//  illegal_instr out  1  sticky trap flag
//  state         out  4  current state (debug)
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7,
//   ALUWB=8, JAL=9, BRANCH=10, TRAP=15.
//  Reset low: state=FETCH, illegal_instr=0. All enables (pc/ir/dmem/regfile) are forced to 0 while reset is low.
//   Muxes are 0 and ALU_control=ADD. Reset mid-instruction abandons it; no write completes.
//  FETCH: adr_sel=0, asel=00, bsel=10, ADD, result_sel=10. ir_wren=pc_wren=mem_ready.
//   Stay in FETCH until mem_ready=1, then go to DECODE.
//  DECODE: asel=01, bsel=01, ximm=B, ADD (alu_out <= oldPC+imm_B). Next state by opcode:
//   0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BRANCH,
//   any other opcode->TRAP.
//  MEMADR: asel=10, bsel=01, ADD; ximm=I for lw, S for sw. lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: adr_sel=1. Hold until mem_ready, then MEMWB. MEMWB: result_sel=01, regfile_wren=1 -> FETCH.
//  MEMWRITE: adr_sel=1, dmem_wren=1. Hold until mem_ready (strobe stays high while waiting) -> FETCH.
//  EXECR: asel=10, bsel=00. EXECI: asel=10, bsel=01, ximm=I. Both go to ALUWB.
//  ALU op from funct3: 000 ADD (SUB if funct7b5 & R-type), 111 AND, 110 OR, 100 XOR, 010 SLT,
//   011 SLTU, 001 SLL, 101 SRL/SRA (SRA if funct7b5). ADDI ignores funct7b5.
//  ALUWB: result_sel=00, regfile_wren=1 -> FETCH.
//  JAL: asel=01, bsel=10, ADD (rd <= oldPC+4 via ALUWB); result_sel=00, pc_wren=1 (PC <= alu_out) -> ALUWB.
//  BRANCH: asel=10, bsel=00, SUB, result_sel=00, pc_wren=taken -> FETCH. taken by funct3:
//   000 Z, 001 !Z, 100 N^V, 101 !(N^V), 110 !C, 111 C; 010/011 -> TRAP, no PC write.
//  TRAP: illegal_instr=1, all enables 0, remain in TRAP until reset.
//  Outputs are combinational from state (plus mem_ready, funct3 and flags). Latency: R/I-type 4 cycles,
//   lw 5, sw 4, jal 4, branch 3, plus one extra cycle per wait cycle of mem_ready=0.
// TESTING
//  add (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; regfile_wren=1 in cycle 4 only, ALU_control=0.
//  lw with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adr_sel=1, then MEMWB, result_sel=01.
//  beq with Z=1 -> pc_wren=1 in BRANCH; with Z=0 -> pc_wren=0. bltu with C=0 -> taken.
//  jal -> DECODE, JAL (pc_wren=1), ALUWB (regfile_wren=1), FETCH.
//  opcode 0x7F -> TRAP after DECODE, illegal_instr stays 1 for 10 cycles, cleared only by reset=0.
//  reset=0 asserted in MEMWRITE -> state=FETCH immediately (async); dmem_wren=0 the same cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM that steps the shared RV32I datapath through
// fetch/decode/execute/memory/writeback, stalling on mem_ready and trapping bad opcodes.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       N,
   input  logic       Z,
   input  logic       C,
   input  logic       V,
   input  logic       mem_ready,
   output logic       pc_wren,
   output logic       ir_wren,
   output logic       adr_sel,
   output logic       dmem_wren,
   output logic       regfile_wren,
   output logic [1:0] alu_asel,
   output logic [1:0] alu_bsel,
   output logic [1:0] result_sel,
   output logic [1:0] ximm_sel,
   output logic [3:0] ALU_control,
   output logic       illegal_instr,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
      MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, JAL = 4'd9,
      BRANCH = 4'd10, TRAP = 4'd15
   } state_t;
   state_t state_q, state_d;
   logic [3:0] alu_fn;
   logic taken, is_sw;
   assign is_sw = opcode == 7'b0100011;
   assign state = state_q;
   assign alu_fn = funct3 == 3'b000 ? ((funct7b5 && state_q == EXECR) ? 4'd1 : 4'd0) :
                   funct3 == 3'b001 ? 4'd7 :
                   funct3 == 3'b010 ? 4'd5 :
                   funct3 == 3'b011 ? 4'd6 :
                   funct3 == 3'b100 ? 4'd4 :
                   funct3 == 3'b101 ? (funct7b5 ? 4'd9 : 4'd8) :
                   funct3 == 3'b110 ? 4'd3 : 4'd2;
   // C is the no-borrow flag of rs1-rs2, so !C means rs1 <u rs2
   assign taken = funct3 == 3'b000 ? Z :
                  funct3 == 3'b001 ? !Z :
                  funct3 == 3'b100 ? (N ^ V) :
                  funct3 == 3'b101 ? !(N ^ V) :
                  funct3 == 3'b110 ? !C :
                  funct3 == 3'b111 ? C : 1'b0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   always_comb begin
      state_d       = state_q;
      pc_wren       = 1'b0;
      ir_wren       = 1'b0;
      adr_sel       = 1'b0;
      dmem_wren     = 1'b0;
      regfile_wren  = 1'b0;
      alu_asel      = 2'b00;
      alu_bsel      = 2'b00;
      result_sel    = 2'b00;
      ximm_sel      = 2'b00;
      ALU_control   = 4'd0;
      illegal_instr = 1'b0;
      case (state_q)
         FETCH: begin
            alu_bsel   = 2'b10;
            result_sel = 2'b10;
            pc_wren    = mem_ready;
            ir_wren    = mem_ready;
            state_d    = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_asel = 2'b01;
            alu_bsel = 2'b01;
            ximm_sel = 2'b10;
            state_d  = (opcode == 7'b0000011 || is_sw) ? MEMADR :
                       opcode == 7'b0110011 ? EXECR :
                       opcode == 7'b0010011 ? EXECI :
                       opcode == 7'b1101111 ? JAL :
                       opcode == 7'b1100011 ? BRANCH : TRAP;
         end
         MEMADR: begin
            alu_asel = 2'b10;
            alu_bsel = 2'b01;
            ximm_sel = is_sw ? 2'b01 : 2'b00;
            state_d  = is_sw ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_sel = 1'b1;
            state_d = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_sel   = 2'b01;
            regfile_wren = 1'b1;
            state_d      = FETCH;
         end
         MEMWRITE: begin
            adr_sel   = 1'b1;
            dmem_wren = 1'b1;
            state_d   = mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alu_asel    = 2'b10;
            ALU_control = alu_fn;
            state_d     = ALUWB;
         end
         EXECI: begin
            alu_asel    = 2'b10;
            alu_bsel    = 2'b01;
            ALU_control = alu_fn;
            state_d     = ALUWB;
         end
         ALUWB: begin
            regfile_wren = 1'b1;
            state_d      = FETCH;
         end
         JAL: begin
            alu_asel = 2'b01;
            alu_bsel = 2'b10;
            pc_wren  = 1'b1;
            state_d  = ALUWB;
         end
         BRANCH: begin
            alu_asel    = 2'b10;
            ALU_control = 4'd1;
            pc_wren     = taken;
            state_d     = funct3[2:1] == 2'b01 ? TRAP : FETCH;
         end
         default: begin
            illegal_instr = 1'b1;
            state_d       = TRAP;
         end
      endcase
      // state_q is already FETCH under reset, but FETCH would otherwise drive enables from mem_ready
      if (!reset) begin
         pc_wren       = 1'b0;
         ir_wren       = 1'b0;
         adr_sel       = 1'b0;
         dmem_wren     = 1'b0;
         regfile_wren  = 1'b0;
         alu_asel      = 2'b00;
         alu_bsel      = 2'b00;
         result_sel    = 2'b00;
         ximm_sel      = 2'b00;
         ALU_control   = 4'd0;
         illegal_instr = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams with a per-cycle expected-output
// scoreboard built from the instruction-class phase sequences.
module tb_multicycle_controller;
   logic clk = 1'b0, reset = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic funct7b5 = 1'b0, N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0, mem_ready = 1'b0;
   logic pc_wren, ir_wren, adr_sel, dmem_wren, regfile_wren, illegal_instr;
   logic [1:0] alu_asel, alu_bsel, result_sel, ximm_sel;
   logic [3:0] ALU_control, state;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
      .pc_wren(pc_wren), .ir_wren(ir_wren), .adr_sel(adr_sel), .dmem_wren(dmem_wren),
      .regfile_wren(regfile_wren), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
      .result_sel(result_sel), .ximm_sel(ximm_sel), .ALU_control(ALU_control),
      .illegal_instr(illegal_instr), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                          OP_SW = 7'b0100011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;

   typedef struct packed {
      logic rst, mr;
      logic [3:0] st;
      logic pc, ir, adr, dw, rw;
      logic [1:0] as, bs, rs, xi;
      logic [3:0] alu;
      logic ill;
   } cyc_t;

   cyc_t sb[$];
   int checks = 0, errors = 0;
   logic [6:0] nx_op = '0;
   logic [2:0] nx_f3 = '0;
   logic nx_f7 = 1'b0;
   logic [3:0] nx_fl = '0;
   logic [21:0] act;

   assign act = {state, pc_wren, ir_wren, adr_sel, dmem_wren, regfile_wren, alu_asel, alu_bsel,
                 result_sel, ximm_sel, ALU_control, illegal_instr};

   function automatic logic [21:0] pk(input cyc_t c);
      return {c.st, c.pc, c.ir, c.adr, c.dw, c.rw, c.as, c.bs, c.rs, c.xi, c.alu, c.ill};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (sb.size() != 0) begin
         cyc_t e;
         e = sb.pop_front();
         chk($sformatf("cycle state%0d", e.st), {10'd0, act}, {10'd0, pk(e)});
      end

   task automatic issue(input cyc_t c);
      @(posedge clk);
      #1;
      reset = c.rst;
      mem_ready = c.mr;
      opcode = nx_op;
      funct3 = nx_f3;
      funct7b5 = nx_f7;
      {N, Z, C, V} = nx_fl;
      sb.push_back(c);
   endtask

   function automatic cyc_t base(input logic [3:0] st);
      cyc_t c;
      c = '0;
      c.rst = 1'b1;
      c.mr = 1'($urandom_range(0, 1));
      c.st = st;
      c.ill = (st == 4'd15);
      return c;
   endfunction

   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit r_type);
      logic [3:0] tab [8];
      tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      if (f3 == 3'd0 && f7 && r_type) return 4'd1;
      if (f3 == 3'd5 && f7) return 4'd9;
      return tab[f3];
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
      logic eq, lt, ltu;
      eq = fl[2];
      lt = fl[3] != fl[0];
      ltu = !fl[1];
      case (f3)
         3'd0: return eq;
         3'd1: return !eq;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return ltu;
         3'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   task automatic reset_seq(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = '0;
         c.mr = 1'b1;
         issue(c);
      end
   endtask

   task automatic trap_seq(input int n);
      for (int i = 0; i < n; i++) issue(base(4'd15));
      reset_seq(2);
   endtask

   task automatic wb_seq();
      cyc_t c;
      c = base(4'd8);
      c.rw = 1'b1;
      issue(c);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic [3:0] fl, input int fw, input int mw, input bit abort);
      cyc_t c;
      bit sw;
      nx_op = op;
      nx_f3 = f3;
      nx_f7 = f7;
      nx_fl = fl;
      sw = (op == OP_SW);
      for (int i = 0; i <= fw; i++) begin
         c = base(4'd0);
         c.mr = (i == fw);
         c.bs = 2'b10;
         c.rs = 2'b10;
         c.pc = c.mr;
         c.ir = c.mr;
         issue(c);
      end
      c = base(4'd1);
      c.as = 2'b01;
      c.bs = 2'b01;
      c.xi = 2'b10;
      issue(c);
      if (op == OP_R || op == OP_I) begin
         c = base(op == OP_R ? 4'd6 : 4'd7);
         c.as = 2'b10;
         c.bs = op == OP_R ? 2'b00 : 2'b01;
         c.alu = ref_alu(f3, f7, op == OP_R);
         issue(c);
         wb_seq();
      end else if (op == OP_LW || sw) begin
         c = base(4'd2);
         c.as = 2'b10;
         c.bs = 2'b01;
         c.xi = sw ? 2'b01 : 2'b00;
         issue(c);
         for (int i = 0; i <= mw; i++) begin
            c = base(sw ? 4'd5 : 4'd3);
            c.mr = (i == mw);
            c.adr = 1'b1;
            c.dw = sw;
            issue(c);
            if (abort) begin
               @(negedge clk);
               #1;
               reset = 1'b0;
               #1;
               chk("async_reset_state", {28'd0, state}, 32'd0);
               chk("async_reset_dmem_wren", {31'd0, dmem_wren}, 32'd0);
               reset_seq(2);
               return;
            end
         end
         if (!sw) begin
            c = base(4'd4);
            c.rs = 2'b01;
            c.rw = 1'b1;
            issue(c);
         end
      end else if (op == OP_JAL) begin
         c = base(4'd9);
         c.as = 2'b01;
         c.bs = 2'b10;
         c.pc = 1'b1;
         issue(c);
         wb_seq();
      end else if (op == OP_BR) begin
         c = base(4'd10);
         c.as = 2'b10;
         c.alu = 4'd1;
         c.pc = br_taken(f3, fl);
         issue(c);
         if (f3 == 3'd2 || f3 == 3'd3) trap_seq(3);
      end else begin
         trap_seq(10);
      end
   endtask

   initial begin
      logic [6:0] ops [7];
      logic [6:0] op;
      ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_JAL, OP_BR, 7'h7F};
      reset_seq(3);
      run_instr(OP_R, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_LW, 3'b010, 1'b0, 4'b0000, 0, 3, 1'b0);
      run_instr(OP_BR, 3'b000, 1'b0, 4'b0100, 0, 0, 1'b0);
      run_instr(OP_BR, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_BR, 3'b110, 1'b0, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_JAL, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_SW, 3'b010, 1'b0, 4'b0000, 1, 0, 1'b0);
      run_instr(OP_SW, 3'b010, 1'b0, 4'b0000, 0, 2, 1'b1);
      run_instr(OP_R, 3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_I, 3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_I, 3'b101, 1'b1, 4'b0000, 0, 0, 1'b0);
      run_instr(7'h7F, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
      run_instr(OP_BR, 3'b011, 1'b0, 4'b0000, 0, 0, 1'b0);
      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 6)];
         if (op == 7'h7F)
            do op = 7'($urandom_range(0, 127));
            while (op inside {OP_R, OP_I, OP_LW, OP_SW, OP_JAL, OP_BR});
         run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                   ((op == OP_SW || op == OP_LW) && $urandom_range(0, 9) == 0));
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
